top_mux_ctrl: RTL and testbench

//  Command sequencer for the system datapath: accepts one command at a time
//  (memory read, memory write, ALU op), pulses the enable of the addressed unit,

---
 rtl/top_mux_ctrl.sv | 137 +++++++++++++
 tb/tb_top_mux_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/top_mux_ctrl.sv
// Command sequencer: accepts one memory/ALU command at a time, strobes the addressed unit,
// waits out its latency, then steers the output mux and holds a valid/ready response.
module top_mux_ctrl #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 20,
    parameter int unsigned OP_W    = 4,
    parameter int unsigned MEM_LAT = 2,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [1:0]        i_cmd_type,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [DATA_W-1:0] i_cmd_wdata,
    input  logic [OP_W-1:0]   i_cmd_op,
    output logic              o_mem_en,
    output logic              o_mem_wr,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_alu_en,
    output logic [OP_W-1:0]   o_alu_op,
    output logic              o_sel,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_out_err,
    output logic              o_busy
);

    localparam int unsigned MAX_LAT = (MEM_LAT > ALU_LAT) ? MEM_LAT : ALU_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MEM_LOAD = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] ALU_LOAD = CNT_W'(ALU_LAT - 1);

    localparam logic [1:0] TYPE_RD  = 2'd0;
    localparam logic [1:0] TYPE_WR  = 2'd1;
    localparam logic [1:0] TYPE_ALU = 2'd2;
    localparam logic [1:0] TYPE_RSV = 2'd3;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_type;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [OP_W-1:0]   r_alu_op;
    logic              r_sel;
    logic              r_err;
    logic              w_accept;

    assign o_cmd_ready = (r_state == StIdle) && !i_rst;
    assign w_accept    = i_cmd_valid && o_cmd_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_nxt = (i_cmd_type == TYPE_RSV) ? StResp : StIssue;
                end
            end
            StIssue: begin
                if (r_type == TYPE_RD) begin
                    w_cnt_nxt   = MEM_LOAD;
                    w_state_nxt = (MEM_LAT == 1) ? StResp : StWait;
                end else if (r_type == TYPE_ALU) begin
                    w_cnt_nxt   = ALU_LOAD;
                    w_state_nxt = (ALU_LAT == 1) ? StResp : StWait;
                end else begin
                    w_state_nxt = StIdle;
                end
            end
            StWait: begin
                w_cnt_nxt = r_cnt - 1'b1;
                // Counter at 1 means the unit's data lands next cycle.
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_nxt = StResp;
                end
            end
            StResp: begin
                if (i_out_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_type      <= TYPE_RD;
            r_cnt       <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_alu_op    <= '0;
            r_sel       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_type <= i_cmd_type;
                r_err  <= (i_cmd_type == TYPE_RSV);
                if (i_cmd_type != TYPE_WR) begin
                    r_sel <= (i_cmd_type == TYPE_ALU);
                end
                if (i_cmd_type == TYPE_RD || i_cmd_type == TYPE_WR) begin
                    r_mem_addr <= i_cmd_addr;
                end
                if (i_cmd_type == TYPE_WR) begin
                    r_mem_wdata <= i_cmd_wdata;
                end
                if (i_cmd_type == TYPE_ALU) begin
                    r_alu_op <= i_cmd_op;
                end
            end
        end
    end

    assign o_mem_en    = (r_state == StIssue) && (r_type == TYPE_RD || r_type == TYPE_WR);
    assign o_mem_wr    = (r_state == StIssue) && (r_type == TYPE_WR);
    assign o_alu_en    = (r_state == StIssue) && (r_type == TYPE_ALU);
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_alu_op    = r_alu_op;
    assign o_sel       = r_sel;
    assign o_out_valid = (r_state == StResp);
    assign o_out_err   = (r_state == StResp) && r_err;
    assign o_busy      = (r_state != StIdle);

endmodule

// File: tb/tb_top_mux_ctrl.sv
// Bench for top_mux_ctrl: behavioural memory/ALU around the controller, scoreboard of
// expected responses filled at command accept and drained by an independent monitor.
module tb_top_mux_ctrl;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 20;
    localparam int OP_W    = 4;
    localparam int MEM_LAT = 2;
    localparam int ALU_LAT = 1;
    localparam logic [DATA_W-1:0] POISON = 20'hBAD00;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_type = 2'd0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic [OP_W-1:0]   cmd_op = '0;
    logic              mem_en, mem_wr, alu_en, sel, out_valid, out_err, busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [OP_W-1:0]   alu_op;
    logic              out_ready = 1'b1;

    top_mux_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .OP_W   (OP_W),
        .MEM_LAT(MEM_LAT),
        .ALU_LAT(ALU_LAT)
    ) u_dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_cmd_valid(cmd_valid),
        .o_cmd_ready(cmd_ready),
        .i_cmd_type (cmd_type),
        .i_cmd_addr (cmd_addr),
        .i_cmd_wdata(cmd_wdata),
        .i_cmd_op   (cmd_op),
        .o_mem_en   (mem_en),
        .o_mem_wr   (mem_wr),
        .o_mem_addr (mem_addr),
        .o_mem_wdata(mem_wdata),
        .o_alu_en   (alu_en),
        .o_alu_op   (alu_op),
        .o_sel      (sel),
        .o_out_valid(out_valid),
        .i_out_ready(out_ready),
        .o_out_err  (out_err),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DATA_W-1:0] init_f(input logic [ADDR_W-1:0] a);
        return {a, ~a, a[3:0]};
    endfunction

    function automatic logic [DATA_W-1:0] alu_f(input logic [OP_W-1:0] op);
        return {op, ~op, op, ~op, op};
    endfunction

    // Environment: memory and ALU units with fixed latency, poisoned while busy.
    logic [DATA_W-1:0] env_mem [256];
    bit                env_wv  [256];
    logic [DATA_W-1:0] rd_q = '0, alu_q = '0;
    int                rd_cnt = 0, alu_cnt = 0;
    logic [DATA_W-1:0] reg_out, alu_out, mux_out;

    always @(posedge clk) begin
        if (rd_cnt > 0) rd_cnt <= rd_cnt - 1;
        if (alu_cnt > 0) alu_cnt <= alu_cnt - 1;
        if (mem_en && mem_wr) begin
            env_mem[mem_addr] <= mem_wdata;
            env_wv[mem_addr]  <= 1'b1;
        end
        if (mem_en && !mem_wr) begin
            rd_q   <= env_wv[mem_addr] ? env_mem[mem_addr] : init_f(mem_addr);
            rd_cnt <= MEM_LAT - 1;
        end
        if (alu_en) begin
            alu_q   <= alu_f(alu_op);
            alu_cnt <= ALU_LAT - 1;
        end
    end

    assign reg_out = (rd_cnt == 0) ? rd_q : POISON;
    assign alu_out = (alu_cnt == 0) ? alu_q : POISON;
    assign mux_out = sel ? alu_out : reg_out;

    // Reference model and scoreboard.
    typedef struct {
        int                typ;
        logic [DATA_W-1:0] data;
        int                acc;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] mdl_mem [256];
    int                n_vec = 0, n_err = 0;
    int                last_typ = -1, last_acc = -10;
    logic [ADDR_W-1:0] last_addr = '0;
    logic [DATA_W-1:0] last_wd = '0;
    logic [OP_W-1:0]   last_op = '0;
    int                n_mem_exp = 0, n_alu_exp = 0, n_mem_seen = 0, n_alu_seen = 0;
    int                rdy_mode = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic send(input int typ, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wd, input logic [OP_W-1:0] op);
        int   n = 0;
        exp_t e;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_type  = typ[1:0];
        cmd_addr  = addr;
        cmd_wdata = wd;
        cmd_op    = op;
        @(negedge clk);
        while (!cmd_ready) begin
            n++;
            if (n > 200) begin
                check("accept_timeout", 32'(n), 32'd0);
                cmd_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        last_typ  = typ;
        last_acc  = cyc;
        last_addr = addr;
        last_wd   = wd;
        last_op   = op;
        e.typ = typ;
        e.acc = cyc;
        e.data = '0;
        case (typ)
            0: begin e.data = mdl_mem[addr]; n_mem_exp++; exp_q.push_back(e); end
            1: begin mdl_mem[addr] = wd; n_mem_exp++; end
            2: begin e.data = alu_f(op); n_alu_exp++; exp_q.push_back(e); end
            default: exp_q.push_back(e);
        endcase
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_type  = 2'($urandom);
        cmd_addr  = ADDR_W'($urandom);
        cmd_wdata = DATA_W'($urandom);
        cmd_op    = OP_W'($urandom);
    endtask

    // cmd_ready must be low for k-1 negedges, then high on the k-th.
    task automatic expect_ready(input int k, input string name);
        for (int i = 1; i <= k; i++) begin
            @(negedge clk);
            check(name, 32'(cmd_ready), 32'(i == k));
        end
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) check(name, 32'(out_valid), 32'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_strobes"}, {26'd0, mem_en, mem_wr, alu_en, sel, out_valid, out_err},
              32'd0);
        check({name, "_regs"}, {mem_wdata, alu_op, busy, cmd_ready}, 32'd0);
        check({name, "_addr"}, 32'(mem_addr), 32'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 2) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: strobe timing/contents and response handshakes.
    initial begin
        exp_t              e;
        logic              pv = 1'b0;
        logic              h_sel = 1'b0, h_err = 1'b0;
        logic [DATA_W-1:0] h_mux = '0;
        int                lat;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
                continue;
            end
            if (mem_en || alu_en) begin
                check("strobe_onehot", 32'(mem_en & alu_en), 32'd0);
                check("strobe_time", 32'(cyc - last_acc), 32'd1);
                if (mem_en) begin
                    n_mem_seen++;
                    check("mem_cmd_type", 32'(last_typ < 2), 32'd1);
                    check("mem_wr", 32'(mem_wr), 32'(last_typ == 1));
                    check("mem_addr", 32'(mem_addr), 32'(last_addr));
                    if (mem_wr) check("mem_wdata", 32'(mem_wdata), 32'(last_wd));
                end
                if (alu_en) begin
                    n_alu_seen++;
                    check("alu_cmd_type", 32'(last_typ == 2), 32'd1);
                    check("alu_op", 32'(alu_op), 32'(last_op));
                end
            end
            if (out_valid) begin
                check("ready_while_valid", 32'(cmd_ready), 32'd0);
                if (!pv) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_response", 32'(out_valid), 32'd0);
                    end else begin
                        e = exp_q[0];
                        lat = (e.typ == 3) ? 1 : (e.typ == 0) ? 1 + MEM_LAT : 1 + ALU_LAT;
                        check("resp_latency", 32'(cyc - e.acc), 32'(lat));
                        h_sel = sel;
                        h_err = out_err;
                        h_mux = mux_out;
                    end
                end else begin
                    check("hold_stable", {11'd0, sel, out_err, mux_out}, {11'd0, h_sel, h_err, h_mux});
                end
                if (out_ready && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("resp_sel", 32'(sel), 32'(e.typ == 2));
                    check("resp_err", 32'(out_err), 32'(e.typ == 3));
                    if (e.typ != 3) check("resp_data", 32'(mux_out), 32'(e.data));
                end
            end
            pv = out_valid;
        end
    end

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mdl_mem[i] = init_f(8'(i));

        // Reset state.
        @(negedge clk);
        check_reset_outputs("reset_init");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(cmd_ready), 32'd1);

        // Reset asserted while a read is waiting on memory.
        send(0, 8'h5A, '0, '0);
        @(negedge clk);
        @(posedge clk);
        #1;
        check("mid_wait_busy", {30'd0, busy, out_valid}, 32'h2);
        rst = 1'b1;
        #1;
        check_reset_outputs("reset_mid_wait");
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_abort", 32'(cmd_ready), 32'd1);
        repeat (5) @(negedge clk);

        // Plain memory read.
        send(0, 8'h3C, '0, '0);
        expect_ready(4, "rd_ready_a4");

        // ALU op with the consumer stalling.
        rdy_mode = 2;
        send(2, '0, '0, 4'h5);
        wait_valid("alu_valid_timeout");
        repeat (3) @(negedge clk);
        rdy_mode = 0;
        expect_ready(2, "alu_ready_after_hs");

        // Write then read-back of the same address.
        send(1, 8'h10, 20'hABCDE, '0);
        expect_ready(2, "wr_ready_a2");
        send(0, 8'h10, '0, '0);
        expect_ready(4, "rd_back_ready");

        // Reserved command.
        send(3, '0, '0, '0);
        expect_ready(2, "rsv_ready_a2");

        // Random mixed stream.
        rdy_mode = 1;
        for (int i = 0; i < 500; i++) begin
            send($urandom_range(0, 3), ADDR_W'($urandom_range(0, 15)), DATA_W'($urandom),
                 OP_W'($urandom));
            if ($urandom_range(0, 3) == 0) @(posedge clk);
        end
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
        check("mem_strobe_count", 32'(n_mem_seen), 32'(n_mem_exp));
        check("alu_strobe_count", 32'(n_alu_seen), 32'(n_alu_exp));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
